// File: rtl/comparador_pkg.sv
// Shared types and constants for the comparator-flag window statistics block.
package comparador_pkg;

    typedef enum logic {
        S_ACUM   = 1'b0,
        S_RELATO = 1'b1
    } estado_t;

    // Flag triples packed as {AmaiorB, AmenorB, AigualB}
    localparam logic [2:0] FLAG_MAIOR = 3'b100;
    localparam logic [2:0] FLAG_MENOR = 3'b010;
    localparam logic [2:0] FLAG_IGUAL = 3'b001;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comparador_janela_stats_contador_evento.sv
// Event counter with synchronous clear and enable; clear wins over enable.
module contador_evento #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/comparador_janela_stats.sv
// Windowed outcome counter for comparator flags with a held valid/ready report.
// Optional longest A==B run tracking is enabled by COMPARADOR_STATS_SEQ_IGUAL_EN.
module comparador_janela_stats
    import comparador_pkg::*;
#(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             AmaiorB,
    input  logic             AmenorB,
    input  logic             AigualB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_maior,
    output logic [CNT_W-1:0] cnt_menor,
    output logic [CNT_W-1:0] cnt_igual,
    output logic [CNT_W-1:0] cnt_erro,
    output logic [CNT_W-1:0] seq_igual
);

    estado_t          r_estado;
    estado_t          w_prox;
    logic [CNT_W-1:0] r_idx;
    logic [2:0]       w_flags;
    logic             w_aceita;
    logic             w_ultimo;
    logic             w_ack;
    logic             w_maior;
    logic             w_menor;
    logic             w_igual;
    logic             w_erro;
    logic [CNT_W-1:0] w_cnt_maior;
    logic [CNT_W-1:0] w_cnt_menor;
    logic [CNT_W-1:0] w_cnt_igual;
    logic [CNT_W-1:0] w_cnt_erro;
    logic [CNT_W-1:0] r_cnt_maior;
    logic [CNT_W-1:0] r_cnt_menor;
    logic [CNT_W-1:0] r_cnt_igual;
    logic [CNT_W-1:0] r_cnt_erro;

    assign w_flags  = {AmaiorB, AmenorB, AigualB};
    assign w_maior  = (w_flags == FLAG_MAIOR);
    assign w_menor  = (w_flags == FLAG_MENOR);
    assign w_igual  = (w_flags == FLAG_IGUAL);
    assign w_erro   = !(w_maior || w_menor || w_igual);
    assign w_aceita = in_valid && in_ready;
    assign w_ultimo = w_aceita && (r_idx == CNT_W'(WINDOW - 1));
    assign w_ack    = (r_estado == S_RELATO) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= S_ACUM;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            S_ACUM:   if (w_ultimo)  w_prox = S_RELATO;
            S_RELATO: if (out_ready) w_prox = S_ACUM;
            default:                 w_prox = S_ACUM;
        endcase
    end

    always_comb begin
        in_ready  = (r_estado == S_ACUM);
        out_valid = (r_estado == S_RELATO);
    end

    always_ff @(posedge clk) begin
        if (rst || w_ack) begin
            r_idx <= '0;
        end else if (w_aceita) begin
            r_idx <= r_idx + CNT_W'(1);
        end
    end

    contador_evento #(.CNT_W(CNT_W)) u_cnt_maior (
        .clk(clk), .rst(rst), .i_clr(w_ack), .i_en(w_aceita && w_maior), .o_cnt(w_cnt_maior)
    );
    contador_evento #(.CNT_W(CNT_W)) u_cnt_menor (
        .clk(clk), .rst(rst), .i_clr(w_ack), .i_en(w_aceita && w_menor), .o_cnt(w_cnt_menor)
    );
    contador_evento #(.CNT_W(CNT_W)) u_cnt_igual (
        .clk(clk), .rst(rst), .i_clr(w_ack), .i_en(w_aceita && w_igual), .o_cnt(w_cnt_igual)
    );
    contador_evento #(.CNT_W(CNT_W)) u_cnt_erro (
        .clk(clk), .rst(rst), .i_clr(w_ack), .i_en(w_aceita && w_erro), .o_cnt(w_cnt_erro)
    );

    // The report must include the last beat, so it is loaded from count + increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_maior <= '0;
            r_cnt_menor <= '0;
            r_cnt_igual <= '0;
            r_cnt_erro  <= '0;
        end else if (w_ultimo) begin
            r_cnt_maior <= w_cnt_maior + CNT_W'(w_maior);
            r_cnt_menor <= w_cnt_menor + CNT_W'(w_menor);
            r_cnt_igual <= w_cnt_igual + CNT_W'(w_igual);
            r_cnt_erro  <= w_cnt_erro  + CNT_W'(w_erro);
        end
    end

    assign cnt_maior = r_cnt_maior;
    assign cnt_menor = r_cnt_menor;
    assign cnt_igual = r_cnt_igual;
    assign cnt_erro  = r_cnt_erro;

`ifdef COMPARADOR_STATS_SEQ_IGUAL_EN
    logic [CNT_W-1:0] w_run;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_max_nxt;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_seq_igual;

    contador_evento #(.CNT_W(CNT_W)) u_cnt_run (
        .clk(clk), .rst(rst),
        .i_clr(w_ack || (w_aceita && !w_igual)),
        .i_en(w_aceita && w_igual),
        .o_cnt(w_run)
    );

    assign w_run_nxt = w_igual ? w_run + CNT_W'(1) : '0;
    assign w_max_nxt = (w_aceita && (w_run_nxt > r_max)) ? w_run_nxt : r_max;

    always_ff @(posedge clk) begin
        if (rst || w_ack) begin
            r_max <= '0;
        end else begin
            r_max <= w_max_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq_igual <= '0;
        end else if (w_ultimo) begin
            r_seq_igual <= w_max_nxt;
        end
    end

    assign seq_igual = r_seq_igual;
`else
    assign seq_igual = '0;
`endif

endmodule

// File: tb/tb_comparador_janela_stats.sv
// Bench for comparador_janela_stats: directed scenarios plus random traffic against a window model.
module tb_comparador_janela_stats;

    localparam int unsigned WINDOW = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] F_MA = 3'b100;
    localparam logic [2:0] F_ME = 3'b010;
    localparam logic [2:0] F_IG = 3'b001;
    localparam logic [2:0] F_00 = 3'b000;
    localparam logic [2:0] F_11 = 3'b110;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             AmaiorB;
    logic             AmenorB;
    logic             AigualB;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_maior;
    logic [CNT_W-1:0] cnt_menor;
    logic [CNT_W-1:0] cnt_igual;
    logic [CNT_W-1:0] cnt_erro;
    logic [CNT_W-1:0] seq_igual;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_pend;
    logic [2:0]  m_win[$];
    int unsigned m_rep[5];

    always #5 clk = ~clk;

    comparador_janela_stats #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .AmaiorB(AmaiorB), .AmenorB(AmenorB), .AigualB(AigualB),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_maior(cnt_maior), .cnt_menor(cnt_menor), .cnt_igual(cnt_igual),
        .cnt_erro(cnt_erro), .seq_igual(seq_igual)
    );

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelo_reset();
        m_pend = 1'b0;
        m_win.delete();
        foreach (m_rep[k]) m_rep[k] = 0;
    endfunction

    // Report from the list of accepted samples: classify each, track the longest A==B run.
    function automatic void modelo_relatorio();
        int unsigned ma = 0, me = 0, ig = 0, er = 0, cur = 0, best = 0;
        foreach (m_win[k]) begin
            if (m_win[k] == F_MA) begin ma++; cur = 0; end
            else if (m_win[k] == F_ME) begin me++; cur = 0; end
            else if (m_win[k] == F_IG) begin
                ig++;
                cur++;
                if (cur > best) best = cur;
            end
            else begin er++; cur = 0; end
        end
        m_rep[0] = ma;
        m_rep[1] = me;
        m_rep[2] = ig;
        m_rep[3] = er;
`ifdef COMPARADOR_STATS_SEQ_IGUAL_EN
        m_rep[4] = best;
`else
        m_rep[4] = 0;
`endif
    endfunction

    task automatic step(input bit r, input bit v, input logic [2:0] f, input bit rdy);
        bit acc;
        @(negedge clk);
        confere("in_ready",  32'(in_ready),  32'(!m_pend));
        confere("out_valid", 32'(out_valid), 32'(m_pend));
        confere("cnt_maior", 32'(cnt_maior), m_rep[0]);
        confere("cnt_menor", 32'(cnt_menor), m_rep[1]);
        confere("cnt_igual", 32'(cnt_igual), m_rep[2]);
        confere("cnt_erro",  32'(cnt_erro),  m_rep[3]);
        confere("seq_igual", 32'(seq_igual), m_rep[4]);
        if (m_pend)
            confere("soma", 32'(cnt_maior) + 32'(cnt_menor) + 32'(cnt_igual) + 32'(cnt_erro), WINDOW);
        rst       = r;
        in_valid  = v;
        {AmaiorB, AmenorB, AigualB} = f;
        out_ready = rdy;
        @(posedge clk);
        if (r) begin
            modelo_reset();
        end else begin
            acc = v && !m_pend;
            if (m_pend && rdy) m_pend = 1'b0;
            if (acc) begin
                m_win.push_back(f);
                if (m_win.size() == WINDOW) begin
                    modelo_relatorio();
                    m_win.delete();
                    m_pend = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [2:0] flag_aleatoria();
        logic [2:0] f;
        case ($urandom_range(0, 3))
            0: f = F_MA;
            1: f = F_ME;
            2: f = F_IG;
            default: f = 3'($urandom);
        endcase
        return f;
    endfunction

    initial begin
        logic [2:0] seq6 [8];
        logic [2:0] mix  [8];
        logic [2:0] errs [8];
        seq6 = '{F_IG, F_IG, F_MA, F_IG, F_IG, F_IG, F_ME, F_IG};
        mix  = '{F_MA, F_ME, F_IG, F_MA, F_ME, F_IG, F_MA, F_ME};
        errs = '{F_MA, F_00, F_ME, F_IG, F_11, F_MA, F_IG, F_ME};

        rst = 1'b1; in_valid = 1'b0; AmaiorB = 1'b0; AmenorB = 1'b0; AigualB = 1'b0; out_ready = 1'b0;
        modelo_reset();
        @(posedge clk);

        // All-equal window, report held while sink stalls with in_valid high
        for (int i = 0; i < 8; i++) step(0, 1, F_IG, 0);
        for (int i = 0; i < 5; i++) step(0, 1, F_MA, 0);
        step(0, 1, F_MA, 1);

        // Mixed window with valid gaps
        for (int i = 0; i < 8; i++) begin
            step(0, 0, F_MA, 0);
            step(0, 1, mix[i], 0);
        end
        step(0, 0, F_00, 1);

        // Non-one-hot samples among valid ones
        for (int i = 0; i < 8; i++) step(0, 1, errs[i], 0);
        step(0, 0, F_00, 1);

        // Reset mid-window, then a clean window
        for (int i = 0; i < 5; i++) step(0, 1, F_ME, 0);
        step(1, 1, F_ME, 0);
        for (int i = 0; i < 8; i++) step(0, 1, seq6[i], 0);
        step(0, 0, F_00, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, flag_aleatoria(),
                 $urandom_range(0, 9) < 4);

        step(0, 0, F_00, 1);
        step(0, 0, F_00, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
